pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_if.sv | 28 ++
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if -- one valid/ready channel carrying a control payload and
// a data payload between two pipeline stages.
//
// Handshake: a transfer happens on a rising clk edge where valid=1 and
// ready=1. The sender holds valid and its payload steady until that transfer
// happens or the pipeline is flushed. ready may change whether or not valid
// is set.
//
// Signals:
//   valid  sender -> receiver   entry offered
//   ready  receiver -> sender   receiver takes the entry this cycle
//   ctrl   sender -> receiver   control payload (CTRL_W bits)
//   data   sender -> receiver   data payload (DATA_W bits)
// Modports:
//   master  the side that produces entries
//   slave   the side that consumes entries
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- one pipeline register stage with a single-entry skid
// buffer. Because of the skid buffer, in_ready can come straight from a flop,
// so there is no combinational path from out_ready back to in_ready. The
// stage still moves one entry per cycle when downstream does not stall.
//
// Parameters:
//   DATA_W           data payload width (operands, immediate, PC)
//   CTRL_W           control payload width (EX/MEM/WB bundle)
//   FLUSH_ZERO_DATA  1: the head data payload is cleared on flush.
//                    0: the head data payload is kept on flush.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      synchronous kill of every held entry; beats a same-cycle accept
//   up         upstream channel (slave): in_valid/in_ready/in_ctrl/in_data
//   dn         downstream channel (master): out_valid/out_ready/out_ctrl/out_data
//   occupancy  number of held entries, 0..2; this is also the FSM state
//              encoding, so it works as the state debug view
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int DATA_W          = 64,
  parameter int CTRL_W          = 22,
  parameter int FLUSH_ZERO_DATA = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  pipe_stage_skid_if.slave         up,
  pipe_stage_skid_if.master        dn,
  output logic [1:0]               occupancy,
  output logic [15:0]              stall_cnt
);

  // The encoding equals the number of held entries. That lets occupancy
  // show the state directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [15:0]       stall_q;

  logic accept;
  logic release_hd;

  assign accept     = up.valid & in_ready_q;
  assign release_hd = out_valid_q & dn.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      // Flush does not clear the stall counter; it keeps counting for the
      // whole run.
      if (out_valid_q && !dn.ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end

      if (flush) begin
        // A release in this cycle already happened downstream. Any accept
        // in this cycle is dropped.
        state_q     <= EMPTY;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        main_ctrl_q <= '0;
        if (FLUSH_ZERO_DATA != 0) begin
          main_data_q <= '0;
        end
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        case (state_q)
          EMPTY: begin
            // Also the first cycle after reset: in_ready rises here.
            in_ready_q <= 1'b1;
            if (accept) begin
              main_ctrl_q <= up.ctrl;
              main_data_q <= up.data;
              out_valid_q <= 1'b1;
              state_q     <= ONE;
            end
          end

          ONE: begin
            case ({accept, release_hd})
              2'b11: begin
                main_ctrl_q <= up.ctrl;
                main_data_q <= up.data;
              end
              2'b10: begin
                // Downstream is stalled. Park the new entry so in_ready can
                // drop one cycle later without losing it.
                skid_ctrl_q <= up.ctrl;
                skid_data_q <= up.data;
                in_ready_q  <= 1'b0;
                state_q     <= FULL;
              end
              2'b01: begin
                // out_ctrl must read zero while nothing is presented. The data
                // payload is left as it was.
                main_ctrl_q <= '0;
                out_valid_q <= 1'b0;
                state_q     <= EMPTY;
              end
              default: begin
              end
            endcase
          end

          FULL: begin
            if (release_hd) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              skid_ctrl_q <= '0;
              skid_data_q <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= ONE;
            end
          end

          default: begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
          end
        endcase
      end
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid_q;
  assign dn.ctrl   = main_ctrl_q;
  assign dn.data   = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 22;
  localparam int EW     = CTRL_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_ZERO_DATA(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // Second copy that keeps its data payload on flush.
  logic        h_flush;
  logic [1:0]  h_occ;
  logic [15:0] h_stall;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) h_up ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) h_dn ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_ZERO_DATA(0)) dut_hold (
    .clk       (clk),
    .rst       (rst),
    .flush     (h_flush),
    .up        (h_up),
    .dn        (h_dn),
    .occupancy (h_occ),
    .stall_cnt (h_stall)
  );

  // ---------------- scoreboard / reference model ----------------
  // The stage is modelled as an in-order queue of at most two entries.
  logic [EW-1:0] exp_q[$];
  logic          m_ready;
  logic [15:0]   m_stall;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [EW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("occupancy", 64'(occupancy), 64'(exp_q.size()));
    check("out_valid", 64'(dn_if.valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(up_if.ready), 64'(m_ready));
    check("out_ctrl", 64'(dn_if.ctrl), 64'(h[EW-1:DATA_W]));
    if (exp_q.size() != 0) check("out_data", dn_if.data, h[DATA_W-1:0]);
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive one cycle of inputs, advance the model, check
  // at the following negedge.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl);
    logic acc, rel;
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
    dn_if.ready = ordy;
    flush       = fl;
    acc = v && m_ready;
    rel = (exp_q.size() != 0) && ordy;
    if ((exp_q.size() != 0) && !ordy && (m_stall != 16'hFFFF)) m_stall++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({c, d});
    end
    m_ready = (exp_q.size() < 2);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  function automatic logic [CTRL_W-1:0] rnd_ctrl();
    logic [31:0] r;
    r = $urandom;
    return r[CTRL_W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    up_if.valid = 0; up_if.ctrl = '0; up_if.data = '0; dn_if.ready = 0; flush = 0;
    h_up.valid = 0; h_up.ctrl = '0; h_up.data = '0; h_dn.ready = 0; h_flush = 0;
    m_ready = 0;
    m_stall = 0;

    // Reset state, sampled while rst is still high.
    repeat (2) @(negedge clk);
    check_all();
    check("rst_out_data", dn_if.data, 64'd0);
    rst = 1'b0;
    idle(1'b1);  // in_ready rises on the first edge after reset

    // Flushing the hold copy with out_ready=1: its head counts as released,
    // and its data payload stays.
    h_up.valid = 1; h_up.ctrl = 22'h5; h_up.data = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    h_up.valid = 0;
    check("hold_valid", 64'(h_dn.valid), 64'd1);
    check("hold_data", h_dn.data, 64'hDEAD_BEEF_0123_4567);
    h_dn.ready = 1; h_flush = 1;
    @(negedge clk);
    h_flush = 0; h_dn.ready = 0;
    check("hold_flush_valid", 64'(h_dn.valid), 64'd0);
    check("hold_flush_occ", 64'(h_occ), 64'd0);
    check("hold_flush_ctrl", 64'(h_dn.ctrl), 64'd0);
    check("hold_flush_data", h_dn.data, 64'hDEAD_BEEF_0123_4567);

    // Streaming 1..4 with out_ready=1.
    for (int i = 1; i <= 4; i++) step(1'b1, 22'(i), 64'(i), 1'b1, 1'b0);
    check("stream_stall", 64'(stall_cnt), 64'd0);
    idle(1'b1);

    // Backpressure: A and B accepted while stalled, then drained in order.
    step(1'b1, 22'h0A, 64'hAAAA, 1'b0, 1'b0);
    step(1'b1, 22'h0B, 64'hBBBB, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("bp_stall3", 64'(stall_cnt), 64'd3);
    idle(1'b1);  // A leaves, in_ready returns
    idle(1'b1);  // B leaves

    // Flush while FULL, with C offered in the same cycle.
    step(1'b1, 22'h11, 64'h1111, 1'b0, 1'b0);
    step(1'b1, 22'h22, 64'h2222, 1'b0, 1'b0);
    step(1'b1, 22'h0C, 64'hCCCC, 1'b0, 1'b1);
    check("flush_data_zero", dn_if.data, 64'd0);
    idle(1'b1);
    idle(1'b1);

    // Flush while ONE, head released in the same cycle.
    step(1'b1, 22'h33, 64'h3333, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset between edges while FULL.
    step(1'b1, 22'h44, 64'h4444, 1'b0, 1'b0);
    step(1'b1, 22'h55, 64'h5555, 1'b0, 1'b0);
    up_if.valid = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(dn_if.valid), 64'd0);
    check("arst_ctrl", 64'(dn_if.ctrl), 64'd0);
    check("arst_data", dn_if.data, 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_ready", 64'(up_if.ready), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    exp_q.delete();
    m_ready = 0;
    m_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    check_all();
    idle(1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_ctrl(), {$urandom, $urandom},
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    // Drain what is left.
    idle(1'b1);
    idle(1'b1);

    // Saturation: hold one entry stalled for more than 65535 cycles.
    step(1'b1, 22'h77, 64'h7777, 1'b0, 1'b0);
    up_if.valid = 0;
    dn_if.ready = 0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    m_stall = 16'hFFFF;
    check("sat_stall", 64'(stall_cnt), 64'hFFFF);
    idle(1'b0);
    check("sat_hold", 64'(stall_cnt), 64'hFFFF);
    idle(1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
